// File: rtl/dmem_pkg.sv
// Shared defaults, types and helpers for the two-requester data-memory arbiter.
package dmem_pkg;

    localparam int unsigned DMEM_OFFSET = 256;
    localparam int unsigned DMEM_DEPTH  = 1024;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
        logic    err;
    } rsp_t;

    // 33-bit compare so OFFSET+DEPTH near 2^32 cannot wrap.
    function automatic logic addrInRange(input logic [31:0] addr,
                                         input int unsigned offset,
                                         input int unsigned depth);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = 33'(offset);
        hi = 33'(offset) + 33'(depth);
        return (a >= lo) && (a < hi);
    endfunction

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake bundle and the synchronous data-memory port bundle.
interface dmem_arbiter_if;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [15:0] accCnt;

    modport master (output valid, addr, wdata, we,
                    input  ready, rvalid, rdata, err, accCnt);
    modport slave  (input  valid, addr, wdata, we,
                    output ready, rvalid, rdata, err, accCnt);
endinterface

interface dmem_mem_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;

    modport master (output addr, wdata, we, input rdata);
    modport slave  (input addr, wdata, we, output rdata);
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, on contention the
// requester not granted most recently wins.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic [1:0] valid_i,
    input  req_id_t    lastGnt_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = valid_i;
        if (valid_i == 2'b11) begin
            gnt_o = lastGnt_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto one synchronous data memory, with range
// checking, one-cycle responses steered by a pending ID, and access counters.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned OFFSET = DMEM_OFFSET,
    parameter int unsigned DEPTH  = DMEM_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  req0,
    dmem_arbiter_if.slave  req1,
    dmem_mem_if.master     mem
);

    logic [1:0]  gntRaw;
    logic [1:0]  gnt;
    logic        anyGnt;
    req_id_t     gntId;
    logic [31:0] selAddr;
    logic [31:0] selWdata;
    logic        selWe;
    logic        inRange;
    logic        rvalid0;
    logic        rvalid1;

    req_id_t     lastGnt_q;
    rsp_t        pend_q;
    rsp_t        pend_d;
    logic [15:0] acc0Cnt_q;
    logic [15:0] acc1Cnt_q;

    rr_arb2 u_arb (
        .valid_i   ({req1.valid, req0.valid}),
        .lastGnt_i (lastGnt_q),
        .gnt_o     (gntRaw)
    );

    // Grants are masked during reset so nothing can be accepted while rst is high.
    assign gnt    = rst ? 2'b00 : gntRaw;
    assign anyGnt = |gnt;
    assign gntId  = gnt[1];

    assign req0.ready = gnt[0];
    assign req1.ready = gnt[1];

    assign selAddr  = gntId ? req1.addr  : req0.addr;
    assign selWdata = gntId ? req1.wdata : req0.wdata;
    assign selWe    = gntId ? req1.we    : req0.we;
    assign inRange  = addrInRange(selAddr, OFFSET, DEPTH);

    assign mem.addr  = anyGnt ? selAddr  : 32'(OFFSET);
    assign mem.wdata = anyGnt ? selWdata : 32'h0;
    assign mem.we    = anyGnt & selWe & inRange;

    always_comb begin
        pend_d       = '0;
        pend_d.valid = anyGnt;
        pend_d.id    = gntId;
        pend_d.err   = anyGnt & ~inRange;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastGnt_q <= 1'b1;
            pend_q    <= '0;
            acc0Cnt_q <= 16'h0;
            acc1Cnt_q <= 16'h0;
        end else begin
            pend_q <= pend_d;
            if (anyGnt) begin
                lastGnt_q <= gntId;
            end
            if (gnt[0]) begin
                acc0Cnt_q <= satInc(acc0Cnt_q);
            end
            if (gnt[1]) begin
                acc1Cnt_q <= satInc(acc1Cnt_q);
            end
        end
    end

    // Memory read data lines up with the pending record one cycle after acceptance.
    assign rvalid0 = pend_q.valid & (pend_q.id == 1'b0);
    assign rvalid1 = pend_q.valid & (pend_q.id == 1'b1);

    assign req0.rvalid = rvalid0;
    assign req0.err    = rvalid0 & pend_q.err;
    assign req0.rdata  = (rvalid0 & ~pend_q.err) ? mem.rdata : 32'h0;
    assign req0.accCnt = acc0Cnt_q;

    assign req1.rvalid = rvalid1;
    assign req1.err    = rvalid1 & pend_q.err;
    assign req1.rdata  = (rvalid1 & ~pend_q.err) ? mem.rdata : 32'h0;
    assign req1.accCnt = acc1Cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter: stimulus pushes expected
// responses, a negedge monitor pops and compares them.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    dmem_arbiter_if req0 ();
    dmem_arbiter_if req1 ();
    dmem_mem_if     mem ();

    dmem_arbiter #(.OFFSET(256), .DEPTH(1024)) dut (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0),
        .req1 (req1),
        .mem  (mem)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] memArr [0:4095];
    exp_t        q0 [$];
    exp_t        q1 [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Synchronous memory: registered read, read-before-write.
    always @(posedge clk) begin
        mem.rdata <= memArr[mem.addr[11:0]];
        if (mem.we) memArr[mem.addr[11:0]] <= mem.wdata;
    end

    function automatic logic [31:0] initVal(input int i);
        return (i == 256) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic expectRsp(input int id, input logic [31:0] rdata, input logic err, input string tag);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.due   = cyc + 1;
        e.tag   = tag;
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] d0, input logic w0,
                                 input logic v1, input logic [31:0] a1, input logic [31:0] d1, input logic w1);
        @(posedge clk);
        #1;
        req0.valid = v0; req0.addr = a0; req0.wdata = d0; req0.we = w0;
        req1.valid = v1; req1.addr = a1; req1.wdata = d1; req1.we = w1;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " ready0"}, 32'(req0.ready), 32'h0);
        checkOutput({tag, " ready1"}, 32'(req1.ready), 32'h0);
        checkOutput({tag, " memWe"}, 32'(mem.we), 32'h0);
        checkOutput({tag, " rvalid0"}, 32'(req0.rvalid), 32'h0);
        checkOutput({tag, " rvalid1"}, 32'(req1.rvalid), 32'h0);
        checkOutput({tag, " err1"}, 32'(req1.err), 32'h0);
        checkOutput({tag, " acc0"}, 32'(req0.accCnt), 32'h0);
        checkOutput({tag, " acc1"}, 32'(req1.accCnt), 32'h0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req0.valid = 1'b1; req0.addr = 32'd256; req0.we = 1'b0;
        req1.valid = 1'b1; req1.addr = 32'd260; req1.we = 1'b1;
        #1;
        checkResetOutputs("reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req0.valid = 1'b0; req1.valid = 1'b0; req1.we = 1'b0;
    endtask

    // Response monitor: every rvalid must match the oldest expectation, on time.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q0.size() > 0 && q0[0].due < cyc) begin
                e = q0.pop_front();
                total++; bad++;
                $display("[TB] FAIL rsp0 missing %s: got no response expected one at cycle %0d", e.tag, e.due);
            end
            while (q1.size() > 0 && q1[0].due < cyc) begin
                e = q1.pop_front();
                total++; bad++;
                $display("[TB] FAIL rsp1 missing %s: got no response expected one at cycle %0d", e.tag, e.due);
            end
            if (req0.rvalid) begin
                if (q0.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL rsp0 unexpected: got rvalid=1 rdata=%h expected rvalid=0", req0.rdata);
                end else begin
                    e = q0.pop_front();
                    checkOutput({e.tag, " cycle"}, 32'(cyc), 32'(e.due));
                    checkOutput({e.tag, " rdata"}, req0.rdata, e.rdata);
                    checkOutput({e.tag, " err"}, 32'(req0.err), 32'(e.err));
                end
            end else begin
                checkOutput("rsp0 idle rdata", req0.rdata, 32'h0);
                checkOutput("rsp0 idle err", 32'(req0.err), 32'h0);
            end
            if (req1.rvalid) begin
                if (q1.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL rsp1 unexpected: got rvalid=1 rdata=%h expected rvalid=0", req1.rdata);
                end else begin
                    e = q1.pop_front();
                    checkOutput({e.tag, " cycle"}, 32'(cyc), 32'(e.due));
                    checkOutput({e.tag, " rdata"}, req1.rdata, e.rdata);
                    checkOutput({e.tag, " err"}, 32'(req1.err), 32'(e.err));
                end
            end else begin
                checkOutput("rsp1 idle rdata", req1.rdata, 32'h0);
                checkOutput("rsp1 idle err", 32'(req1.err), 32'h0);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4096; i++) memArr[i] = initVal(i);
        rst = 1'b1;
        req0.valid = 1'b0; req0.addr = 32'h0; req0.wdata = 32'h0; req0.we = 1'b0;
        req1.valid = 1'b0; req1.addr = 32'h0; req1.wdata = 32'h0; req1.we = 1'b0;
        doReset();

        // Single read of the lowest valid word.
        applyStimulus(1'b1, 32'd256, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("A ready0", 32'(req0.ready), 32'h1);
        checkOutput("A ready1", 32'(req1.ready), 32'h0);
        checkOutput("A memAddr", mem.addr, 32'd256);
        checkOutput("A memWe", 32'(mem.we), 32'h0);
        expectRsp(0, 32'hDEADBEEF, 1'b0, "A read256");
        applyStimulus(1'b0, 32'd700, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("A idle memAddr", mem.addr, 32'd256);
        checkOutput("A idle memWe", 32'(mem.we), 32'h0);

        // Contention straight after reset: 0,1,0,1.
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'd260, 32'h0, 1'b0, 1'b1, 32'd261, 32'h0, 1'b0);
            checkOutput($sformatf("B%0d ready0", i), 32'(req0.ready), (i % 2 == 0) ? 32'h1 : 32'h0);
            checkOutput($sformatf("B%0d ready1", i), 32'(req1.ready), (i % 2 == 1) ? 32'h1 : 32'h0);
            if (i % 2 == 0) expectRsp(0, 32'hC0DE0104, 1'b0, $sformatf("B%0d rsp0", i));
            else            expectRsp(1, 32'hC0DE0105, 1'b0, $sformatf("B%0d rsp1", i));
        end
        idle();
        checkOutput("B acc0", 32'(req0.accCnt), 32'd2);
        checkOutput("B acc1", 32'(req1.accCnt), 32'd2);

        // Write returns old contents; following read sees new data.
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd300, 32'h12345678, 1'b1);
        checkOutput("C ready1", 32'(req1.ready), 32'h1);
        checkOutput("C memWe", 32'(mem.we), 32'h1);
        checkOutput("C memWdata", mem.wdata, 32'h12345678);
        expectRsp(1, 32'hC0DE012C, 1'b0, "C write300");
        applyStimulus(1'b1, 32'd300, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("C ready0", 32'(req0.ready), 32'h1);
        expectRsp(0, 32'h12345678, 1'b0, "C read300");

        // Range boundaries: 100, 1280 and 255 outside; 1279 inside.
        applyStimulus(1'b1, 32'd100, 32'hAAAA5555, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("D100 ready0", 32'(req0.ready), 32'h1);
        checkOutput("D100 memWe", 32'(mem.we), 32'h0);
        expectRsp(0, 32'h0, 1'b1, "D write100");
        applyStimulus(1'b1, 32'd1280, 32'hAAAA5555, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("D1280 memWe", 32'(mem.we), 32'h0);
        expectRsp(0, 32'h0, 1'b1, "D write1280");
        applyStimulus(1'b1, 32'd255, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        expectRsp(0, 32'h0, 1'b1, "D read255");
        applyStimulus(1'b1, 32'd1279, 32'h0BADF00D, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("D1279 memWe", 32'(mem.we), 32'h1);
        expectRsp(0, 32'hC0DE04FF, 1'b0, "D write1279");
        applyStimulus(1'b1, 32'd1279, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        expectRsp(0, 32'h0BADF00D, 1'b0, "D read1279");
        idle();
        checkOutput("D mem100 unchanged", memArr[100], 32'hC0DE0064);
        checkOutput("D mem1280 unchanged", memArr[1280], 32'hC0DE0500);

        // Reset right after a req1 accept drops its response.
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'd400, 32'h0, 1'b0);
        checkOutput("E ready1", 32'(req1.ready), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req0.valid = 1'b1; req0.addr = 32'd256; req0.we = 1'b0;
        req1.valid = 1'b1; req1.addr = 32'd260; req1.we = 1'b0;
        #1;
        checkResetOutputs("E rst");
        @(posedge clk);
        #1;
        checkResetOutputs("E rst hold");
        rst = 1'b0;
        #1;
        checkOutput("E release ready0", 32'(req0.ready), 32'h1);
        checkOutput("E release ready1", 32'(req1.ready), 32'h0);
        expectRsp(0, 32'hDEADBEEF, 1'b0, "E first grant");
        applyStimulus(1'b1, 32'd256, 32'h0, 1'b0, 1'b1, 32'd260, 32'h0, 1'b0);
        checkOutput("E second ready1", 32'(req1.ready), 32'h1);
        expectRsp(1, 32'hC0DE0104, 1'b0, "E second grant");
        idle();

        // Counter saturation from a preloaded near-max value.
        @(posedge clk);
        #1;
        force dut.acc0Cnt_q = 16'hFFFE;
        #2;
        release dut.acc0Cnt_q;
        checkOutput("F preload acc0", 32'(req0.accCnt), 32'h0000FFFE);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'd256, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            checkOutput($sformatf("F%0d acc0", i), 32'(req0.accCnt), (i == 0) ? 32'h0000FFFE : 32'h0000FFFF);
            expectRsp(0, 32'hDEADBEEF, 1'b0, $sformatf("F%0d read256", i));
        end
        idle();
        checkOutput("F final acc0", 32'(req0.accCnt), 32'h0000FFFF);
        checkOutput("F final acc1", 32'(req1.accCnt), 32'h1);

        idle();
        idle();
        checkOutput("end q0 empty", 32'(q0.size()), 32'h0);
        checkOutput("end q1 empty", 32'(q1.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter OFFSET, default 256, meaning lowest valid data-memory word address.
REQ-002 The block SHALL have parameter DEPTH, default 1024, meaning number of 32-bit words in data memory.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have ports reqN_valid  input  1  requester N (N=0,1) access request.
REQ-006 The block SHALL have ports reqN_ready  output  1  grant; transfer occurs when reqN_valid and reqN_ready are both high at a rising edge.
REQ-007 The block SHALL have ports reqN_addr  input  32  word address; reqN_wdata  input  32  write data; reqN_we  input  1  write (1) or read (0).
REQ-008 The block SHALL have ports reqN_rvalid  output  1  response strobe; reqN_rdata  output  32  read data; reqN_err  output  1  address-out-of-range flag.
REQ-009 The block SHALL have ports mem_addr  output  32, mem_wdata  output  32, mem_we  output  1, mem_rdata  input  32, connecting to the synchronous data memory (one-cycle registered read, read-before-write).
REQ-010 The block SHALL have ports accN_cnt  output  16  saturating count of accepted transfers for requester N.

Function
REQ-011 Arbitration SHALL be combinational in the current cycle: at most one of req0_ready/req1_ready high; readyN high only if reqN_valid high.
REQ-012 With only one requester valid, that requester SHALL be granted every cycle (no bubbles).
REQ-013 With both valid, grant SHALL go to the requester not granted most recently (last_gnt register, updated on each transfer; reset value 1, so req0 wins first contention).
REQ-014 Granted request fields SHALL drive mem_addr/mem_wdata combinationally; with no grant, mem_we SHALL be 0 and mem_addr SHALL hold OFFSET.
REQ-015 In range means OFFSET <= addr <= OFFSET+DEPTH-1; out-of-range transfers SHALL be accepted but mem_we forced 0.
REQ-016 Each transfer SHALL produce exactly one response: reqN_rvalid high for one cycle, the cycle after the accepting edge (latency 1).
REQ-017 Response reqN_rdata SHALL equal mem_rdata for in-range transfers (reads and writes; writes return pre-write contents) and 32'h0 for out-of-range; reqN_err SHALL be 1 only for out-of-range.
REQ-018 Responses SHALL be steered by a registered pending ID; back-to-back transfers SHALL yield back-to-back responses, including alternating IDs.
REQ-019 reqN_rdata SHALL be 0 and reqN_err 0 whenever reqN_rvalid is 0.
REQ-020 accN_cnt SHALL increment by 1 per accepted transfer of requester N and saturate at 16'hFFFF.

Reset
REQ-021 While rst is high: all readys, rvalids, errs, mem_we SHALL be 0; accN_cnt 0; last_gnt 1; pending response cleared.
REQ-022 A response pending when rst asserts SHALL be dropped (never delivered); first grant possible in the first cycle after rst deasserts.

Structure
REQ-023 OFFSET/DEPTH defaults, requester-ID typedef (1 bit) and response record (valid, id, err) SHALL live in shared package dmem_pkg.
REQ-024 Two-way round-robin grant logic SHALL be sub-module rr_arb2 (inputs two valids, last_gnt; outputs one-hot grant).

Verification
REQ-025 req0 read addr 256 (mem word 256 = 32'hDEADBEEF) alone -> req0_ready=1 same cycle; next cycle req0_rvalid=1, rdata=32'hDEADBEEF, err=0.
REQ-026 Both valid for 4 cycles after reset -> grants 0,1,0,1; rvalid alternates 0,1,0,1 one cycle later; acc0_cnt=2, acc1_cnt=2.
REQ-027 req1 write addr 300 data 32'h12345678, then req0 read 300 -> write response rdata = old value; read response rdata=32'h12345678.
REQ-028 req0 write addr 100 and addr 1280 -> mem_we=0 both cycles, req0_err=1, rdata=0; memory unchanged.
REQ-029 rst asserted in the cycle after a req1 accept -> req1_rvalid stays 0; all outputs 0 asynchronously; req0 granted the first cycle after release.
REQ-030 Force acc0_cnt to 16'hFFFE, issue 3 req0 transfers -> acc0_cnt=16'hFFFF, held.
